uart_tx_param: RTL
==================

UART_TX_PARAM -- requirements
Module: uart_tx_param

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 10416: clock cycles per serial bit, legal range 2..65535.
REQ-002 SHALL provide parameter DATA_BITS, default 8: payload bits per frame, legal range 5..9.
REQ-003 SHALL provide parameter STOP_BITS, default 1: stop bits per frame, legal values 1 or 2.
REQ-004 SHALL provide parameter GUARD_CYCLES, default 2500: idle-high cycles after the stop bit(s) before the next accept, legal range 0..2^20-1.
REQ-005 SHALL provide parameter PARITY_ODD, default 0: 0 selects even parity, 1 selects odd; used only when UART_TX_PARITY_EN is defined.
REQ-006 SHALL provide port clk, input, 1: the single clock; all state is updated on its rising edge.
REQ-007 SHALL provide port rst_n, input, 1: reset, asynchronous assert and active-low.
REQ-008 SHALL provide port data_send, input, DATA_BITS: payload, LSB transmitted first.
REQ-009 SHALL provide port transmit, input, 1: request/valid, level-sensitive.
REQ-010 SHALL provide port ready, output, 1: high only in IDLE.
REQ-011 SHALL provide port Txd, output, 1: serial line, idle high.
REQ-012 SHALL provide port Done, output, 1: one-cycle pulse at the end of the last stop bit.

Function
REQ-013 SHALL implement the states IDLE, START, DATA, PARITY, STOP and GUARD.
REQ-014 SHALL accept a frame only on a clk edge where the state is IDLE and transmit=1 (accept = transmit & ready); on accept it captures data_send into an internal register and moves to START.
REQ-015 SHALL restart the baud counter at accept; the counter is not free-running, so every bit, including the start bit, lasts exactly CLKS_PER_BIT cycles.
REQ-016 SHALL drive Txd low beginning on the first cycle after accept (latency 1), for CLKS_PER_BIT cycles.
REQ-017 SHALL in DATA shift out DATA_BITS bits LSB first, using a bit counter that runs 0..DATA_BITS-1, then move to PARITY if parity is enabled, otherwise to STOP.
REQ-018 SHALL in PARITY drive the XOR of the captured payload (XNOR when PARITY_ODD=1) for one bit time.
REQ-019 SHALL in STOP drive Txd high for STOP_BITS bit times, and assert Done for exactly one cycle on the final cycle of the last stop bit.
REQ-020 SHALL after STOP enter GUARD and hold Txd high for GUARD_CYCLES cycles, then return to IDLE; when GUARD_CYCLES=0 it SHALL go from STOP directly to IDLE.
REQ-021 SHALL make the total accept-to-ready time equal CLKS_PER_BIT*(1+DATA_BITS+P+STOP_BITS)+GUARD_CYCLES cycles, where P=1 if parity is enabled and P=0 otherwise.
REQ-022 SHALL ignore changes on data_send and transmit outside IDLE; a transmit still held high at return to IDLE starts a new frame on that same cycle.
REQ-023 SHALL register Txd so that it is glitch-free, and SHALL never drive X on Txd, including in unreachable states, which recover to IDLE with Txd=1.
REQ-024 SHALL size its counters to $clog2 of their maximum value, and the baud and guard counters SHALL never wrap.

Reset
REQ-025 SHALL while rst_n=0 immediately force state=IDLE, Txd=1, Done=0 and ready=1, and clear all counters and the payload register.
REQ-026 SHALL abort any frame on a reset asserted mid-frame, with Txd going high asynchronously and no Done pulse.
REQ-027 SHALL after rst_n deasserts accept a frame on the first clk edge where transmit=1.

Configuration
REQ-028 SHALL insert the parity bit between the last data bit and the first stop bit when the macro UART_TX_PARITY_EN is defined.
REQ-029 SHALL omit the PARITY state and parity logic entirely when UART_TX_PARITY_EN is undefined, with the frame being start + data + stop only.

Verification (CLKS_PER_BIT=4, GUARD_CYCLES=3 unless stated)
REQ-030 SHALL cover: DATA_BITS=8, STOP_BITS=1, no parity, data_send=8'hA5 pulsed 1 cycle -> Txd=0,1,0,1,0,0,1,0,1,1, each held 4 cycles; Done pulses at cycle 40 after accept; ready returns at cycle 43.
REQ-031 SHALL cover: UART_TX_PARITY_EN defined, PARITY_ODD=0, data_send=8'h07 -> parity bit=1; with PARITY_ODD=1 -> parity bit=0; frame length 44 cycles plus guard.
REQ-032 SHALL cover: DATA_BITS=5, STOP_BITS=2, data_send=5'h1F -> start + five 1s + two stop bits = 32 cycles to Done.
REQ-033 SHALL cover: transmit held high continuously with data_send changing mid-frame -> the first frame carries the value sampled at accept; back-to-back frames are separated by exactly GUARD_CYCLES idle cycles.
REQ-034 SHALL cover: rst_n pulsed low during data bit 3 -> Txd=1 within the reset window, no Done pulse; the next transmit produces a complete correct frame.
REQ-035 SHALL cover: GUARD_CYCLES=0 -> ready rises the cycle after Done, and a held transmit starts the next start bit with no idle gap.

Source files
------------

// File: rtl/uart_tx_param_if.sv
// -----------------------------------------------------------------------------
// uart_tx_param_if
// Handshake and serial-line bundle for the uart_tx_param transmitter.
//
// Signals:
//   data_send [DATA_BITS] : payload offered by the producer, LSB sent first
//   transmit              : level-sensitive request/valid from the producer
//   ready                 : transmitter idle and able to accept this cycle
//   Txd                   : registered serial line, idle high
//   Done                  : one-cycle pulse on the final cycle of the last stop bit
//
// Modports:
//   master : producer side (drives data_send/transmit, observes the rest)
//   slave  : transmitter side
// -----------------------------------------------------------------------------
interface uart_tx_param_if #(
  parameter int DATA_BITS = 8
);
  logic [DATA_BITS-1:0] data_send;
  logic                 transmit;
  logic                 ready;
  logic                 Txd;
  logic                 Done;

  modport master (
    output data_send,
    output transmit,
    input  ready,
    input  Txd,
    input  Done
  );

  modport slave (
    input  data_send,
    input  transmit,
    output ready,
    output Txd,
    output Done
  );
endinterface

// File: rtl/uart_tx_param.sv
// -----------------------------------------------------------------------------
// uart_tx_param
// Parameterised UART transmitter: start bit, DATA_BITS payload bits LSB first,
// optional parity bit, STOP_BITS stop bits, then GUARD_CYCLES idle-high cycles
// before the next frame can be accepted.
//
// Optional feature: define UART_TX_PARITY_EN to insert a parity bit between
// the last data bit and the first stop bit (PARITY_ODD selects odd parity).
// Without the macro the frame is start + data + stop only.
//
// Ports:
//   clk   : single clock, rising edge
//   rst_n : asynchronous, active-low reset
//   bus   : uart_tx_param_if.slave (data_send, transmit, ready, Txd, Done)
// -----------------------------------------------------------------------------
module uart_tx_param #(
  parameter int CLKS_PER_BIT = 10416,
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int GUARD_CYCLES = 2500,
  parameter int PARITY_ODD   = 0
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_tx_param_if.slave bus
);

  // Counters hold 0..N-1, so N itself sets the width.
  localparam int BAUD_W  = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int BIT_W   = $clog2(DATA_BITS);
  localparam int GUARD_W = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;

  localparam logic [BAUD_W-1:0]  BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]   BIT_LAST   = BIT_W'(DATA_BITS - 1);
  localparam logic [BIT_W-1:0]   STOP_LAST  = BIT_W'(STOP_BITS - 1);
  localparam logic [GUARD_W-1:0] GUARD_LAST =
    GUARD_W'((GUARD_CYCLES > 0) ? (GUARD_CYCLES - 1) : 0);

  if (CLKS_PER_BIT < 2 || CLKS_PER_BIT > 65535) begin : g_bad_clks
    $error("uart_tx_param: CLKS_PER_BIT out of range 2..65535");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_param: DATA_BITS out of range 5..9");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_param: STOP_BITS must be 1 or 2");
  end
  if (GUARD_CYCLES < 0 || GUARD_CYCLES > 1048575) begin : g_bad_guard
    $error("uart_tx_param: GUARD_CYCLES out of range 0..2^20-1");
  end
  if (PARITY_ODD != 0 && PARITY_ODD != 1) begin : g_bad_parity
    $error("uart_tx_param: PARITY_ODD must be 0 or 1");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd3,
`endif
    STOP   = 3'd4,
    GUARD  = 3'd5
  } state_t;

  state_t               state, state_n;
  logic [BAUD_W-1:0]    baud_cnt, baud_n;
  logic [BIT_W-1:0]     bit_cnt, bit_n;
  logic [GUARD_W-1:0]   guard_cnt, guard_n;
  logic [DATA_BITS-1:0] sh_q, sh_n;
  logic                 txd_q, txd_n;
  logic                 done_q, done_n;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_n;
`endif

  wire baud_last = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      guard_cnt <= '0;
      sh_q      <= '0;
      txd_q     <= 1'b1;
      done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q     <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      baud_cnt  <= baud_n;
      bit_cnt   <= bit_n;
      guard_cnt <= guard_n;
      sh_q      <= sh_n;
      txd_q     <= txd_n;
      done_q    <= done_n;
`ifdef UART_TX_PARITY_EN
      par_q     <= par_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    baud_n  = baud_cnt;
    bit_n   = bit_cnt;
    guard_n = guard_cnt;
    sh_n    = sh_q;
    txd_n   = 1'b1;
    done_n  = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_n   = par_q;
`endif

    case (state)
      IDLE: begin
        if (bus.transmit) begin
          state_n = START;
          baud_n  = '0;
          bit_n   = '0;
          sh_n    = bus.data_send;
`ifdef UART_TX_PARITY_EN
          par_n   = (^bus.data_send) ^ (PARITY_ODD == 1);
`endif
        end
      end

      START: begin
        if (baud_last) begin
          baud_n  = '0;
          state_n = DATA;
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end

      // The shift register's LSB is always the bit on the line.
      DATA: begin
        if (baud_last) begin
          baud_n = '0;
          sh_n   = sh_q >> 1;
          if (bit_cnt == BIT_LAST) begin
            bit_n = '0;
`ifdef UART_TX_PARITY_EN
            state_n = PARITY;
`else
            state_n = STOP;
`endif
          end else begin
            bit_n = bit_cnt + 1'b1;
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end

`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_last) begin
          baud_n  = '0;
          state_n = STOP;
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end
`endif

      // bit_cnt is reused here to count stop bits.
      STOP: begin
        if (baud_last) begin
          baud_n = '0;
          if (bit_cnt == STOP_LAST) begin
            bit_n   = '0;
            guard_n = '0;
            state_n = (GUARD_CYCLES == 0) ? IDLE : GUARD;
          end else begin
            bit_n = bit_cnt + 1'b1;
          end
        end else begin
          baud_n = baud_cnt + 1'b1;
        end
      end

      GUARD: begin
        if (guard_cnt == GUARD_LAST) begin
          guard_n = '0;
          state_n = IDLE;
        end else begin
          guard_n = guard_cnt + 1'b1;
        end
      end

      // Unused encodings fall back to a clean idle line.
      default: begin
        state_n = IDLE;
        baud_n  = '0;
        bit_n   = '0;
        guard_n = '0;
      end
    endcase

    // Txd is a registered function of the next state, so it changes exactly
    // on the bit boundaries and never glitches.
    case (state_n)
      START:   txd_n = 1'b0;
      DATA:    txd_n = sh_n[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  txd_n = par_q;
`endif
      default: txd_n = 1'b1;
    endcase

    // Registered so that Done is high during the final stop-bit cycle.
    done_n = (state_n == STOP) && (baud_n == BAUD_LAST) && (bit_n == STOP_LAST);
  end

  assign bus.ready = (state == IDLE);
  assign bus.Txd   = txd_q;
  assign bus.Done  = done_q;

endmodule
